// File: rtl/riscv_pkg.sv
// Shared encodings for the multi-cycle RISC-V main controller: opcodes,
// controller states and the ALU operand/operation select codes.
package riscv_pkg;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXEC_R = 4'd6,
      RWB    = 4'd7,
      EXEC_I = 4'd8,
      IWB    = 4'd9,
      BRANCH = 4'd10
   } state_t;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_AREG  = 2'b10;

   localparam logic [1:0] SRCB_BREG = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;

endpackage

// File: rtl/main_control_fsm.sv
// Multi-cycle RISC-V main controller: one state register, next-state logic
// and a Moore output decoder with mem_ready-gated memory strobes.
//
// state  | meaning
// FETCH  | read instruction at PC, PC+4 into PC when memory completes
// DECODE | opcode dispatch, branch target into ALUOut
// MEMADR | load/store effective address A + imm
// MEMRD  | load data read, wait for memory
// MEMWB  | load data written to register file
// MEMWR  | store data write, wait for memory
// EXEC_R | R-type ALU operation
// RWB    | R-type result writeback
// EXEC_I | I-ALU operation with immediate
// IWB    | I-ALU result writeback
// BRANCH | beq compare, PC <- ALUOut when zero
module main_control_fsm
   import riscv_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] opcode,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       Branch,
   output logic       PCSource,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic       illegal,
   output logic       retired,
   output logic [3:0] state
);

   state_t state_q, state_d;

   always_comb begin
      state_d = FETCH;
      case (state_q)
         FETCH:  state_d = mem_ready ? DECODE : FETCH;
         DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_R:         state_d = EXEC_R;
               OP_I:         state_d = EXEC_I;
               OP_BEQ:       state_d = BRANCH;
               default:      state_d = FETCH;
            endcase
         end
         MEMADR: state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
         MEMRD:  state_d = mem_ready ? MEMWB : MEMRD;
         MEMWB:  state_d = FETCH;
         MEMWR:  state_d = mem_ready ? FETCH : MEMWR;
         EXEC_R: state_d = RWB;
         RWB:    state_d = FETCH;
         EXEC_I: state_d = IWB;
         IWB:    state_d = FETCH;
         BRANCH: state_d = FETCH;
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= FETCH;
      else        state_q <= state_d;
   end

   // Decoder is gated by rst_n so a reset landing mid-wait kills every
   // strobe at once, not just after the state register has settled.
   always_comb begin
      PCWrite  = 1'b0;
      Branch   = 1'b0;
      PCSource = 1'b0;
      IorD     = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      MemtoReg = 1'b0;
      RegWrite = 1'b0;
      ALUSrcA  = SRCA_PC;
      ALUSrcB  = SRCB_BREG;
      ALUOp    = ALUOP_ADD;
      illegal  = 1'b0;
      retired  = 1'b0;
      if (rst_n) begin
         case (state_q)
            FETCH: begin
               MemRead = 1'b1;
               ALUSrcB = SRCB_FOUR;
               IRWrite = mem_ready;
               PCWrite = mem_ready;
            end
            DECODE: begin
               ALUSrcA = SRCA_OLDPC;
               ALUSrcB = SRCB_IMM;
               illegal = !(opcode inside {OP_LW, OP_SW, OP_R, OP_I, OP_BEQ});
            end
            MEMADR, EXEC_I: begin
               ALUSrcA = SRCA_AREG;
               ALUSrcB = SRCB_IMM;
            end
            MEMRD: begin
               MemRead = 1'b1;
               IorD    = 1'b1;
            end
            MEMWB: begin
               RegWrite = 1'b1;
               MemtoReg = 1'b1;
               retired  = 1'b1;
            end
            MEMWR: begin
               MemWrite = 1'b1;
               IorD     = 1'b1;
               retired  = mem_ready;
            end
            EXEC_R: begin
               ALUSrcA = SRCA_AREG;
               ALUOp   = ALUOP_RTYPE;
            end
            RWB, IWB: begin
               RegWrite = 1'b1;
               retired  = 1'b1;
            end
            BRANCH: begin
               ALUSrcA  = SRCA_AREG;
               ALUOp    = ALUOP_SUB;
               Branch   = 1'b1;
               PCSource = 1'b1;
               retired  = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_main_control_fsm.sv
// Self-checking bench for main_control_fsm: a directed vector table, two
// hand-written reset sequences and random traffic against an instruction-level model.
module tb_main_control_fsm;

   localparam logic Z = 1'b0;
   localparam logic H = 1'b1;
   localparam logic [6:0] LW  = 7'b0000011;
   localparam logic [6:0] SW  = 7'b0100011;
   localparam logic [6:0] RT  = 7'b0110011;
   localparam logic [6:0] IA  = 7'b0010011;
   localparam logic [6:0] BQ  = 7'b1100011;
   localparam logic [6:0] BAD = 7'b1111111;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] opcode;
   logic       mem_ready;
   logic       PCWrite, Branch, PCSource, IorD, MemRead, MemWrite, IRWrite;
   logic       MemtoReg, RegWrite, illegal, retired;
   logic [1:0] ALUSrcA, ALUSrcB, ALUOp;
   logic [3:0] state;
   logic [16:0] act;

   int vectors = 0;
   int miscompares = 0;
   int m_state;
   int m_plan[$];

   always #5 clk = ~clk;

   main_control_fsm dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .Branch(Branch), .PCSource(PCSource), .IorD(IorD),
      .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .illegal(illegal), .retired(retired),
      .state(state)
   );

   assign act = {PCWrite, Branch, PCSource, IorD, MemRead, MemWrite, IRWrite,
                 MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, illegal, retired};

   function automatic logic [16:0] pk(input logic pcw, br, pcs, iord, mrd, mwr,
                                      irw, m2r, rw, input logic [1:0] sa, sb, ao,
                                      input logic il, rt);
      return {pcw, br, pcs, iord, mrd, mwr, irw, m2r, rw, sa, sb, ao, il, rt};
   endfunction

   // Expected control word for each step of an instruction's life.
   function automatic logic [16:0] exp_out(input int s, input logic mr,
                                           input logic [6:0] op, input logic rn);
      logic legal;
      legal = op inside {LW, SW, RT, IA, BQ};
      if (!rn) return '0;
      case (s)
         0:  return pk(mr,Z,Z,Z,H,Z,mr,Z,Z, 2'b00,2'b01,2'b00, Z,Z);
         1:  return pk(Z,Z,Z,Z,Z,Z,Z,Z,Z, 2'b01,2'b10,2'b00, !legal,Z);
         2:  return pk(Z,Z,Z,Z,Z,Z,Z,Z,Z, 2'b10,2'b10,2'b00, Z,Z);
         3:  return pk(Z,Z,Z,H,H,Z,Z,Z,Z, 2'b00,2'b00,2'b00, Z,Z);
         4:  return pk(Z,Z,Z,Z,Z,Z,Z,H,H, 2'b00,2'b00,2'b00, Z,H);
         5:  return pk(Z,Z,Z,H,Z,H,Z,Z,Z, 2'b00,2'b00,2'b00, Z,mr);
         6:  return pk(Z,Z,Z,Z,Z,Z,Z,Z,Z, 2'b10,2'b00,2'b10, Z,Z);
         7:  return pk(Z,Z,Z,Z,Z,Z,Z,Z,H, 2'b00,2'b00,2'b00, Z,H);
         8:  return pk(Z,Z,Z,Z,Z,Z,Z,Z,Z, 2'b10,2'b10,2'b00, Z,Z);
         9:  return pk(Z,Z,Z,Z,Z,Z,Z,Z,H, 2'b00,2'b00,2'b00, Z,H);
         10: return pk(Z,H,H,Z,Z,Z,Z,Z,Z, 2'b10,2'b00,2'b01, Z,H);
         default: return '0;
      endcase
   endfunction

   // Instruction-level model: after FETCH completes, DECODE lays out the
   // remaining steps of the instruction as a queue; memory steps wait on mem_ready.
   task automatic advance(input logic [6:0] op, input logic mr);
      if (m_state == 0) begin
         if (mr) m_state = 1;
      end else begin
         if (m_state == 1) begin
            case (op)
               LW:      m_plan = '{2, 3, 4};
               SW:      m_plan = '{2, 5};
               RT:      m_plan = '{6, 7};
               IA:      m_plan = '{8, 9};
               BQ:      m_plan = '{10};
               default: m_plan.delete();
            endcase
         end
         if (!((m_state == 3 || m_state == 5) && !mr)) begin
            if (m_plan.size() > 0) m_state = m_plan.pop_front();
            else                   m_state = 0;
         end
      end
   endtask

   task automatic check(input string tag, input logic [3:0] est, input logic [16:0] eout);
      vectors++;
      if (state !== est || act !== eout) begin
         miscompares++;
         $display("FAIL %s: got state=%0d ctl=%05h, expected state=%0d ctl=%05h",
                  tag, state, act, est, eout);
      end
      vectors++;
      if (MemRead === 1'b1 && MemWrite === 1'b1) begin
         miscompares++;
         $display("FAIL %s mem_excl: got MemRead=1 MemWrite=1, expected not both", tag);
      end
   endtask

   task automatic step(input string tag, input logic [6:0] op, input logic mr, input logic rn);
      @(negedge clk);
      opcode = op;
      mem_ready = mr;
      rst_n = rn;
      if (!rn) begin
         m_state = 0;
         m_plan.delete();
      end
      #1;
      check(tag, 4'(m_state), exp_out(m_state, mr, op, rn));
      if (rn) advance(op, mr);
   endtask

   typedef struct packed {
      logic [6:0]  op;
      logic        mr;
      logic [3:0]  st;
      logic [16:0] ctl;
   } vec_t;

   vec_t tbl[$];

   initial begin
      logic [16:0] f1, f0, dec, deci, madr, mrd, mwb, mwr0, mwr1, exr, wb, exi, brq;
      logic [6:0]  rop;
      f1   = pk(H,Z,Z,Z,H,Z,H,Z,Z, 2'b00,2'b01,2'b00, Z,Z);
      f0   = pk(Z,Z,Z,Z,H,Z,Z,Z,Z, 2'b00,2'b01,2'b00, Z,Z);
      dec  = pk(Z,Z,Z,Z,Z,Z,Z,Z,Z, 2'b01,2'b10,2'b00, Z,Z);
      deci = pk(Z,Z,Z,Z,Z,Z,Z,Z,Z, 2'b01,2'b10,2'b00, H,Z);
      madr = pk(Z,Z,Z,Z,Z,Z,Z,Z,Z, 2'b10,2'b10,2'b00, Z,Z);
      mrd  = pk(Z,Z,Z,H,H,Z,Z,Z,Z, 2'b00,2'b00,2'b00, Z,Z);
      mwb  = pk(Z,Z,Z,Z,Z,Z,Z,H,H, 2'b00,2'b00,2'b00, Z,H);
      mwr0 = pk(Z,Z,Z,H,Z,H,Z,Z,Z, 2'b00,2'b00,2'b00, Z,Z);
      mwr1 = pk(Z,Z,Z,H,Z,H,Z,Z,Z, 2'b00,2'b00,2'b00, Z,H);
      exr  = pk(Z,Z,Z,Z,Z,Z,Z,Z,Z, 2'b10,2'b00,2'b10, Z,Z);
      wb   = pk(Z,Z,Z,Z,Z,Z,Z,Z,H, 2'b00,2'b00,2'b00, Z,H);
      exi  = pk(Z,Z,Z,Z,Z,Z,Z,Z,Z, 2'b10,2'b10,2'b00, Z,Z);
      brq  = pk(Z,H,H,Z,Z,Z,Z,Z,Z, 2'b10,2'b00,2'b01, Z,H);

      // R-type, beq, illegal (with a fetch wait), ANDI, sw with a wait, lw with two waits
      tbl.push_back('{RT, H, 4'd0, f1});   tbl.push_back('{RT, H, 4'd1, dec});
      tbl.push_back('{RT, H, 4'd6, exr});  tbl.push_back('{RT, H, 4'd7, wb});
      tbl.push_back('{BQ, H, 4'd0, f1});   tbl.push_back('{BQ, H, 4'd1, dec});
      tbl.push_back('{BQ, H, 4'd10, brq});
      tbl.push_back('{BAD, Z, 4'd0, f0});  tbl.push_back('{BAD, H, 4'd0, f1});
      tbl.push_back('{BAD, H, 4'd1, deci});
      tbl.push_back('{IA, H, 4'd0, f1});   tbl.push_back('{IA, H, 4'd1, dec});
      tbl.push_back('{IA, H, 4'd8, exi});  tbl.push_back('{IA, H, 4'd9, wb});
      tbl.push_back('{SW, H, 4'd0, f1});   tbl.push_back('{SW, H, 4'd1, dec});
      tbl.push_back('{SW, H, 4'd2, madr}); tbl.push_back('{SW, Z, 4'd5, mwr0});
      tbl.push_back('{SW, H, 4'd5, mwr1});
      tbl.push_back('{LW, H, 4'd0, f1});   tbl.push_back('{LW, H, 4'd1, dec});
      tbl.push_back('{LW, H, 4'd2, madr}); tbl.push_back('{LW, Z, 4'd3, mrd});
      tbl.push_back('{LW, Z, 4'd3, mrd});  tbl.push_back('{LW, H, 4'd3, mrd});
      tbl.push_back('{LW, H, 4'd4, mwb});  tbl.push_back('{LW, H, 4'd0, f1});

      // Reset held with mem_ready high: FETCH must stay silent.
      m_state = 0;
      step("reset0", RT, 1'b1, 1'b0);
      step("reset1", RT, 1'b1, 1'b0);

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         opcode = tbl[i].op;
         mem_ready = tbl[i].mr;
         rst_n = 1'b1;
         #1;
         check($sformatf("tbl%0d", i), tbl[i].st, tbl[i].ctl);
         advance(tbl[i].op, tbl[i].mr);
      end

      // sw into a MEMWR wait, then reset mid-cycle between clock edges.
      step("sw_dec", SW, 1'b1, 1'b1);
      step("sw_adr", SW, 1'b1, 1'b1);
      step("sw_wait0", SW, 1'b0, 1'b1);
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      check("sw_wait1", 4'd5, mwr0);
      #1 rst_n = 1'b0;
      #1;
      check("sw_async_rst", 4'd0, '0);
      m_state = 0;
      m_plan.delete();
      step("sw_rst_hold", SW, 1'b1, 1'b0);
      step("post_fetch", RT, 1'b1, 1'b1);
      step("post_dec", RT, 1'b1, 1'b1);
      step("post_exec", RT, 1'b1, 1'b1);
      step("post_wb", RT, 1'b1, 1'b1);

      // Random traffic: opcode only changes between instructions, occasional resets.
      rop = RT;
      for (int c = 0; c < 3000; c++) begin
         logic mr, rn;
         if (m_state == 0) begin
            case ($urandom_range(0, 5))
               0: rop = LW;
               1: rop = SW;
               2: rop = RT;
               3: rop = IA;
               4: rop = BQ;
               default: rop = 7'($urandom);
            endcase
         end
         mr = ($urandom_range(0, 3) != 0);
         rn = ($urandom_range(0, 49) != 0);
         step($sformatf("rand%0d", c), rop, mr, rn);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/main_control_fsm.md
MAIN_CONTROL_FSM -- requirements
Module: main_control_fsm

Interface
REQ-001 The block SHALL have one clock `clk`; reset `rst_n` SHALL be asynchronous and active-low.
REQ-002 The ports SHALL be:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  async active-low reset
- `opcode`  in  7  instruction register bits [6:0]
- `mem_ready`  in  1  memory completes the current access this cycle
- `PCWrite`  out  1  unconditional PC load
- `Branch`  out  1  PC load if ALU zero
- `PCSource`  out  1  PC source: 0 = ALU result, 1 = ALUOut
- `IorD`  out  1  memory address: 0 = PC, 1 = ALUOut
- `MemRead`  out  1  memory read request
- `MemWrite`  out  1  memory write request
- `IRWrite`  out  1  instruction register load
- `MemtoReg`  out  1  writeback source: 1 = MDR, 0 = ALUOut
- `RegWrite`  out  1  register file write
- `ALUSrcA`  out  2  ALU A input: 00 = PC, 01 = OldPC, 10 = A register
- `ALUSrcB`  out  2  ALU B input: 00 = B register, 01 = constant 4, 10 = immediate
- `ALUOp`  out  2  to the ALU control: 00 = add/funct3-select, 01 = sub, 10 = R-type
- `illegal`  out  1  one-cycle pulse on an unsupported opcode
- `retired`  out  1  one-cycle pulse when an instruction completes
- `state`  out  4  current state, for debug

Function
REQ-003 The state encoding SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC_R=6, RWB=7, EXEC_I=8, IWB=9, BRANCH=10.
REQ-004 Outputs SHALL be Moore, decoded from `state` only, except that the FETCH and MEM* strobes listed below are gated by `mem_ready`.
REQ-005 Any signal not listed for a state SHALL be 0 in that state.
REQ-006 FETCH SHALL assert MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=01, ALUOp=00, PCSource=0.
REQ-007 In FETCH, IRWrite and PCWrite SHALL both equal `mem_ready`.
REQ-008 FETCH SHALL go to DECODE when `mem_ready`=1 and otherwise hold, with no cycle limit.
REQ-009 DECODE SHALL drive ALUSrcA=01, ALUSrcB=10, ALUOp=00 (branch target into ALUOut).
REQ-010 DECODE SHALL branch on `opcode`:
- 0000011 (lw) or 0100011 (sw) -> MEMADR
- 0110011 (R-type) -> EXEC_R
- 0010011 (I-ALU) -> EXEC_I
- 1100011 (beq) -> BRANCH
- any other value -> FETCH with `illegal`=1 for that one cycle
REQ-011 MEMADR SHALL drive ALUSrcA=10, ALUSrcB=10, ALUOp=00.
REQ-012 MEMADR SHALL go to MEMRD when the opcode is lw and to MEMWR otherwise, using the opcode held in the IR.
REQ-013 MEMRD SHALL drive MemRead=1, IorD=1, and SHALL go to MEMWB on `mem_ready` and otherwise hold.
REQ-014 MEMWB SHALL drive RegWrite=1, MemtoReg=1, retired=1, and SHALL then go to FETCH.
REQ-015 MEMWR SHALL drive MemWrite=1, IorD=1, and retired=`mem_ready`.
REQ-016 MEMWR SHALL go to FETCH on `mem_ready` and otherwise hold.
REQ-017 EXEC_R SHALL drive ALUSrcA=10, ALUSrcB=00, ALUOp=10, and SHALL then go to RWB.
REQ-018 EXEC_I SHALL drive ALUSrcA=10, ALUSrcB=10, ALUOp=00, and SHALL then go to IWB; the ALU control selects ANDI from funct3 under ALUOp=00.
REQ-019 RWB and IWB SHALL drive RegWrite=1, MemtoReg=0, retired=1, and SHALL then go to FETCH.
REQ-020 BRANCH SHALL drive ALUSrcA=10, ALUSrcB=00, ALUOp=01, Branch=1, PCSource=1, retired=1, and SHALL then go to FETCH.
REQ-021 Unreachable state codes 11-15 SHALL go to FETCH on the next edge with all strobes 0.
REQ-022 Instruction latency (FETCH with `mem_ready` tied high through writeback, inclusive) SHALL be:
- lw: 5 cycles
- sw, R-type, I-ALU: 4 cycles
- beq: 3 cycles
REQ-023 MemRead and MemWrite SHALL never be asserted in the same cycle.

Reset
REQ-024 Asserting `rst_n`=0 SHALL force `state` to FETCH immediately, without waiting for a clock edge.
REQ-025 While in reset, all strobes SHALL be 0, including during a FETCH state; `ALUSrcA`, `ALUSrcB` and `ALUOp` SHALL be 00.
REQ-026 A reset asserted mid-instruction, including during a `mem_ready` wait, SHALL abandon the instruction with no RegWrite, MemWrite or PCWrite.
REQ-027 After reset release, the first rising edge SHALL evaluate FETCH normally.

Structure
REQ-028 A shared package `riscv_pkg` SHALL hold:
- the opcode constants (OP_R, OP_I, OP_LW, OP_SW, OP_BEQ)
- the state encoding
- the ALUOp encoding
- the ALUSrcA and ALUSrcB encodings
REQ-029 The block SHALL have no sub-module; it is one state register, next-state logic and an output decoder.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- R-type, opcode=0110011, `mem_ready`=1 -> states 0,1,6,7; ALUOp=10 in state 6; RegWrite=1 and retired=1 in state 7 only.
- lw, opcode=0000011, with `mem_ready` low for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4; RegWrite and MemtoReg = 1 only in state 4.
- beq, opcode=1100011 -> states 0,1,10; in state 10 ALUOp=01, Branch=1, PCSource=1; back in FETCH on the next cycle.
- Illegal opcode 1111111 -> `illegal` pulses for 1 cycle in DECODE, next state is FETCH, RegWrite and MemWrite never assert.
- sw with `rst_n` driven low during a MEMWR wait -> `state`=0 asynchronously and MemWrite drops in the same cycle; after release the next instruction fetches normally.
- Assertion, in every scenario: MemRead and MemWrite are never both 1, and ANDI (opcode 0010011) produces ALUOp=00 in EXEC_I.
